// File: rtl/chart_writer_pkg.sv
// Local types for chart_writer: recorder FSM state encoding.
package chart_writer_pkg;
  import ddr_pkg::*;

  typedef enum logic [1:0] {IDLE, REC, FLUSH, DONE} state_t;
endpackage

// File: rtl/ddr_pkg.sv
// Shared dance-chart definitions: arrow bit positions inside an entry's
// arrow field, timing field width, and the packed chart entry layout.
package ddr_pkg;
  localparam int LEFT  = 3;
  localparam int UP    = 2;
  localparam int DOWN  = 1;
  localparam int RIGHT = 0;
  localparam int TIMEW = 4;

  typedef struct packed {
    logic [3:0]       arrows;
    logic [TIMEW-1:0] timing;
  } chart_entry_t;
endpackage

// File: rtl/chart_writer_if.sv
// Chart memory write channel: valid/ready handshake with address and
// entry payload. master = recorder, slave = chart memory.
interface chart_writer_if #(parameter int ADDRW = 6) ();
  logic             wr_valid_o;
  logic             wr_ready_i;
  logic [ADDRW-1:0] wr_addr_o;
  logic [3:0]       wr_arrows_o;
  logic [3:0]       wr_timing_o;

  modport master (output wr_valid_o, wr_addr_o, wr_arrows_o, wr_timing_o,
                  input  wr_ready_i);
  modport slave  (input  wr_valid_o, wr_addr_o, wr_arrows_o, wr_timing_o,
                  output wr_ready_i);
endinterface

// File: rtl/step_accum.sv
// Press mask / frame gap accumulator.
// Ports: clk_pix, rst_pix (sync, active-high); clr restarts a recording;
// en gates all activity (recording and not full); frame closes a frame;
// stop closes the recording; press = {left,up,down,right} pulses.
// due/entry: an entry is to be written this cycle (combinational).
module step_accum
  import ddr_pkg::*;
#(
  parameter int GAPMAX = 15
) (
  input  logic         clk_pix,
  input  logic         rst_pix,
  input  logic         clr,
  input  logic         en,
  input  logic         frame,
  input  logic         stop,
  input  logic [3:0]   press,
  output logic         due,
  output chart_entry_t entry
);
  localparam logic [TIMEW-1:0] GAP_REST = TIMEW'(GAPMAX);

  logic [3:0]       mask, mask_nx;
  logic [TIMEW-1:0] gap, gap_inc;
  logic             rest;

  // A press coincident with frame is folded into the closing frame.
  always_comb begin
    mask_nx      = mask | (en ? press : 4'b0000);
    gap_inc      = gap + 1'b1;
    rest         = (mask_nx == 4'b0000) && (gap_inc == GAP_REST);
    due          = 1'b0;
    entry.arrows = mask_nx;
    entry.timing = gap;
    if (en && frame) begin
      if (mask_nx != 4'b0000) begin
        due = 1'b1;
      end else if (rest) begin
        due          = 1'b1;
        entry.arrows = 4'b0000;
        entry.timing = GAP_REST;
      end
    end else if (en && stop && mask_nx != 4'b0000) begin
      due = 1'b1;
    end
  end

  // gap starts at 0 so the first entry counts frames from start.
  always_ff @(posedge clk_pix) begin
    if (rst_pix || clr) begin
      mask <= '0;
      gap  <= '0;
    end else if (en) begin
      if (frame) begin
        if (mask_nx != 4'b0000 || rest) begin
          mask <= '0;
          gap  <= TIMEW'(1);
        end else begin
          gap  <= gap_inc;
        end
      end else if (stop) begin
        mask <= '0;
      end else begin
        mask <= mask_nx;
      end
    end
  end
endmodule

// File: rtl/chart_writer.sv
// Dance chart recorder: accumulates debounced arrow presses per video
// frame and writes {arrows, frames-since-previous} entries to chart memory.
// Ports: clk_pix, rst_pix (sync, active-high); frame_i vblank pulse;
// start_i/stop_i recording control; btn_*_i press pulses; wr = write
// channel (master); count_o entries written; busy_o recording or flushing;
// full_o data limit reached; err_o sticky dropped-entry flag.
// Build option: CHART_WRITER_TERM_EN appends a {0000,0} terminator entry
// in FLUSH and reserves one slot for it (data limit DEPTH-1).
module chart_writer
  import ddr_pkg::*;
  import chart_writer_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDRW  = $clog2(DEPTH),
  parameter int GAPMAX = 15
) (
  input  logic           clk_pix,
  input  logic           rst_pix,
  input  logic           frame_i,
  input  logic           start_i,
  input  logic           stop_i,
  input  logic           btn_left_i,
  input  logic           btn_up_i,
  input  logic           btn_down_i,
  input  logic           btn_right_i,
  chart_writer_if.master wr,
  output logic [ADDRW:0] count_o,
  output logic           busy_o,
  output logic           full_o,
  output logic           err_o
);
`ifdef CHART_WRITER_TERM_EN
  localparam bit TERM_EN = 1'b1;
`else
  localparam bit TERM_EN = 1'b0;
`endif
  localparam int             LIMIT_I = TERM_EN ? DEPTH - 1 : DEPTH;
  localparam logic [ADDRW:0] LIMIT   = LIMIT_I[ADDRW:0];

  state_t           state, state_nx;
  logic             pend, term_sent;
  chart_entry_t     pend_entry, due_entry;
  logic [ADDRW-1:0] addr;
  logic [ADDRW:0]   count_nx;
  logic [3:0]       press;
  logic             clr, rec, due, hs, load_data, load_term, drop;

  always_comb begin
    press        = '0;
    press[LEFT]  = btn_left_i;
    press[UP]    = btn_up_i;
    press[DOWN]  = btn_down_i;
    press[RIGHT] = btn_right_i;
  end

  assign full_o = (count_o >= LIMIT);
  assign busy_o = (state == REC) || (state == FLUSH);
  assign clr    = start_i && (state == IDLE || state == DONE);
  assign rec    = (state == REC) && !full_o;

  step_accum #(.GAPMAX(GAPMAX)) u_accum (
    .clk_pix (clk_pix),
    .rst_pix (rst_pix),
    .clr     (clr),
    .en      (rec),
    .frame   (frame_i),
    .stop    (stop_i),
    .press   (press),
    .due     (due),
    .entry   (due_entry)
  );

  // A slot freed by this cycle's handshake may be refilled at once; an
  // entry that would exceed the data limit is silently ignored.
  always_comb begin
    hs        = pend && wr.wr_ready_i;
    count_nx  = count_o + (ADDRW+1)'(hs);
    load_data = due && (!pend || hs) && (count_nx < LIMIT);
    drop      = due && pend && !hs;
    load_term = TERM_EN && (state == FLUSH) && !pend && !term_sent;
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start_i) state_nx = REC;
      REC:   if (stop_i || full_o) state_nx = FLUSH;
      FLUSH: if (!pend && (!TERM_EN || term_sent)) state_nx = DONE;
      DONE:  if (start_i) state_nx = REC;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      pend       <= 1'b0;
      pend_entry <= '0;
      addr       <= '0;
      count_o    <= '0;
      err_o      <= 1'b0;
      term_sent  <= 1'b0;
    end else if (clr) begin
      addr       <= '0;
      count_o    <= '0;
      err_o      <= 1'b0;
      term_sent  <= 1'b0;
    end else begin
      if (hs) begin
        addr    <= addr + 1'b1;
        count_o <= count_nx;
      end
      if (load_data) begin
        pend       <= 1'b1;
        pend_entry <= due_entry;
      end else if (load_term) begin
        pend       <= 1'b1;
        pend_entry <= '0;
        term_sent  <= 1'b1;
      end else if (hs) begin
        pend       <= 1'b0;
      end
      if (drop) err_o <= 1'b1;
    end
  end

  assign wr.wr_valid_o  = pend;
  assign wr.wr_addr_o   = addr;
  assign wr.wr_arrows_o = pend_entry.arrows;
  assign wr.wr_timing_o = pend_entry.timing;
endmodule

// File: tb/tb_chart_writer.sv
// Directed bench for chart_writer: dut_a (DEPTH=64) covers recording,
// backpressure, overflow, stop-flush and reset; dut_b (DEPTH=4) covers the
// full path. sel steers the shared stimulus to one DUT at a time.
module tb_chart_writer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, frame, start, stop, bl, bu, bd, br, sel;
  logic [6:0] cnt_a;
  logic [2:0] cnt_b;
  logic busy_a, full_a, err_a, busy_b, full_b, err_b;
  int n_assert = 0;
  int n_fail   = 0;

  chart_writer_if #(.ADDRW(6)) ifa ();
  chart_writer_if #(.ADDRW(2)) ifb ();

  chart_writer #(.DEPTH(64)) dut_a (
    .clk_pix(clk), .rst_pix(rst), .frame_i(frame & ~sel),
    .start_i(start & ~sel), .stop_i(stop & ~sel),
    .btn_left_i(bl & ~sel), .btn_up_i(bu & ~sel),
    .btn_down_i(bd & ~sel), .btn_right_i(br & ~sel),
    .wr(ifa), .count_o(cnt_a), .busy_o(busy_a), .full_o(full_a), .err_o(err_a)
  );

  chart_writer #(.DEPTH(4)) dut_b (
    .clk_pix(clk), .rst_pix(rst), .frame_i(frame & sel),
    .start_i(start & sel), .stop_i(stop & sel),
    .btn_left_i(bl & sel), .btn_up_i(bu & sel),
    .btn_down_i(bd & sel), .btn_right_i(br & sel),
    .wr(ifb), .count_o(cnt_b), .busy_o(busy_b), .full_o(full_b), .err_o(err_b)
  );

`ifdef CHART_WRITER_TERM_EN
  localparam int LIM_B = 3;
`else
  localparam int LIM_B = 4;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_pulse();
    frame = 1'b1; tick(); frame = 1'b0;
  endtask

  task automatic press(input logic [3:0] m);
    {bl, bu, bd, br} = m; tick(); {bl, bu, bd, br} = 4'b0000;
  endtask

  task automatic start_pulse();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  initial begin
    {frame, start, stop, bl, bu, bd, br, sel} = '0;
    ifa.wr_ready_i = 1'b0;
    ifb.wr_ready_i = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_valid", ifa.wr_valid_o, 0);
    chk("rst_count", cnt_a, 0);
    chk("rst_busy",  busy_a, 0);
    chk("rst_full",  full_a, 0);
    chk("rst_err",   err_a, 0);

    // left press in the third frame after start
    ifa.wr_ready_i = 1'b1;
    start_pulse();
    chk("start_busy", busy_a, 1);
    repeat (3) frame_pulse();
    press(4'b1000);
    frame_pulse();
    chk("e0_valid",  ifa.wr_valid_o, 1);
    chk("e0_addr",   ifa.wr_addr_o, 0);
    chk("e0_arrows", ifa.wr_arrows_o, 4'b1000);
    chk("e0_timing", ifa.wr_timing_o, 3);
    tick();
    chk("e0_done_valid", ifa.wr_valid_o, 0);
    chk("e0_count", cnt_a, 1);
    chk("e0_addr_inc", ifa.wr_addr_o, 1);

    // up, then right coincident with frame: one combined entry
    press(4'b0100);
    {bl, bu, bd, br} = 4'b0001; frame = 1'b1; tick();
    {bl, bu, bd, br} = 4'b0000; frame = 1'b0;
    chk("e1_valid",  ifa.wr_valid_o, 1);
    chk("e1_arrows", ifa.wr_arrows_o, 4'b0101);
    chk("e1_timing", ifa.wr_timing_o, 1);
    chk("e1_addr",   ifa.wr_addr_o, 1);
    tick();
    chk("e1_count", cnt_a, 2);

    // stop with empty mask, then rest entry after 15 idle frames
    stop = 1'b1; tick(); stop = 1'b0;
    chk("flush_busy", busy_a, 1);
    tick();
    chk("done_busy", busy_a, 0);
    chk("done_count", cnt_a, 2);
    start_pulse();
    chk("restart_count", cnt_a, 0);
    repeat (14) frame_pulse();
    chk("rest_early_valid", ifa.wr_valid_o, 0);
    frame_pulse();
    chk("rest_valid",  ifa.wr_valid_o, 1);
    chk("rest_arrows", ifa.wr_arrows_o, 4'b0000);
    chk("rest_timing", ifa.wr_timing_o, 15);
    tick();
    chk("rest_count", cnt_a, 1);

    // backpressure: first entry held, second dropped with err
    ifa.wr_ready_i = 1'b0;
    press(4'b1000);
    frame_pulse();
    chk("bp_valid", ifa.wr_valid_o, 1);
    tick(); tick();
    chk("bp_hold_valid",  ifa.wr_valid_o, 1);
    chk("bp_hold_arrows", ifa.wr_arrows_o, 4'b1000);
    press(4'b0010);
    frame_pulse();
    chk("bp_err",    err_a, 1);
    chk("bp_arrows", ifa.wr_arrows_o, 4'b1000);
    chk("bp_timing", ifa.wr_timing_o, 1);
    chk("bp_addr",   ifa.wr_addr_o, 1);
    ifa.wr_ready_i = 1'b1;
    tick();
    chk("bp_drain_valid", ifa.wr_valid_o, 0);
    chk("bp_count", cnt_a, 2);

    // stop with pending mask flushes a final entry
    press(4'b0001);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("fin_valid",  ifa.wr_valid_o, 1);
    chk("fin_arrows", ifa.wr_arrows_o, 4'b0001);
    chk("fin_timing", ifa.wr_timing_o, 1);
    chk("fin_busy",   busy_a, 1);
    tick();
    chk("fin_count", cnt_a, 3);
    chk("fin_busy2", busy_a, 1);
    tick();
    chk("fin_done_busy", busy_a, 0);
    chk("err_sticky", err_a, 1);
    start_pulse();
    chk("start_clr_err", err_a, 0);
    chk("start_clr_count", cnt_a, 0);

    // reset while an entry is pending
    press(4'b1000);
    frame_pulse();
    tick();
    chk("pre_rst_count", cnt_a, 1);
    ifa.wr_ready_i = 1'b0;
    press(4'b0100);
    frame_pulse();
    chk("pre_rst_valid", ifa.wr_valid_o, 1);
    rst = 1'b1; tick();
    chk("rst2_valid", ifa.wr_valid_o, 0);
    chk("rst2_count", cnt_a, 0);
    chk("rst2_busy",  busy_a, 0);
    rst = 1'b0;
    ifa.wr_ready_i = 1'b1;
    press(4'b1000);
    frame_pulse();
    tick();
    chk("idle_ignore_valid", ifa.wr_valid_o, 0);
    chk("idle_ignore_count", cnt_a, 0);

    // DEPTH=4: one press per frame until full
    sel = 1'b1;
    ifb.wr_ready_i = 1'b1;
    start_pulse();
    for (int i = 0; i < LIM_B; i++) begin
      press(4'b1000);
      frame_pulse();
      chk("b_valid",  ifb.wr_valid_o, 1);
      chk("b_addr",   ifb.wr_addr_o, i);
      chk("b_timing", ifb.wr_timing_o, (i == 0) ? 0 : 1);
      tick();
      chk("b_count", cnt_b, i + 1);
    end
    chk("b_full", full_b, 1);
    press(4'b0001);
    frame_pulse();
`ifdef CHART_WRITER_TERM_EN
    chk("b_term_valid",  ifb.wr_valid_o, 1);
    chk("b_term_arrows", ifb.wr_arrows_o, 0);
    chk("b_term_timing", ifb.wr_timing_o, 0);
    chk("b_term_addr",   ifb.wr_addr_o, 3);
    tick(); tick();
`endif
    chk("b_done_valid", ifb.wr_valid_o, 0);
    chk("b_done_busy",  busy_b, 0);
    chk("b_done_count", cnt_b, 4);
    chk("b_done_full",  full_b, 1);
    chk("b_err", err_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
